systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder.sv | 131 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an N x N systolic array: buffers A and B, then drives diagonally skewed, zero-padded edges.
// Optional job counter output enabled by defining SKEW_FEEDER_JOB_CNT_EN.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge,
  output logic            edge_valid,
  output logic            acc_clr,
  output logic            busy,
  output logic            done
`ifdef SKEW_FEEDER_JOB_CNT_EN
  ,
  output logic [15:0]     job_cnt
`endif
);

  localparam int NN         = N * N;
  localparam int AW         = $clog2(NN);
  localparam int IW         = $clog2(2 * NN);
  localparam int FEED_SLOTS = 3 * N - 2;
  localparam int TW         = $clog2(3 * N);

  typedef enum logic [2:0] {LOAD, CLR, FEED, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   t;
  logic [TW-1:0]   slot;
  logic            accept;
  logic            load_edges;
  logic [N*DW-1:0] a_nxt, b_nxt;
  logic [DW-1:0]   a_mem [NN];
  logic [DW-1:0]   b_mem [NN];

  assign accept = s_valid && (state == LOAD) && !rst;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    acc_clr    = 1'b0;
    busy       = 1'b1;
    edge_valid = 1'b0;
    done       = 1'b0;
    load_edges = 1'b0;
    slot       = '0;
    unique case (state)
      LOAD: begin
        busy    = 1'b0;
        s_ready = !rst;
        if (accept && idx == IW'(2 * NN - 1)) state_nxt = CLR;
      end
      CLR: begin
        acc_clr    = 1'b1;
        load_edges = 1'b1;
        state_nxt  = FEED;
      end
      FEED: begin
        edge_valid = 1'b1;
        if (t == TW'(FEED_SLOTS - 1)) begin
          state_nxt = DRAIN;
        end else begin
          load_edges = 1'b1;
          slot       = t + 1'b1;
        end
      end
      DRAIN: if (t == TW'(N - 1)) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Edge values for the upcoming slot; registered so the buses change only on the slot boundary.
  always_comb begin
    int k;
    k     = 0;
    a_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(slot) - i;
      if (k >= 0 && k < N) begin
        a_nxt[i*DW +: DW] = a_mem[AW'(i * N + k)];
        b_nxt[i*DW +: DW] = b_mem[AW'(k * N + i)];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      idx    <= '0;
      t      <= '0;
      a_edge <= '0;
      b_edge <= '0;
    end else begin
      state <= state_nxt;
      if (accept) idx <= (state_nxt == CLR) ? '0 : idx + 1'b1;
      if (state == LOAD || state_nxt != state) t <= '0;
      else                                     t <= t + 1'b1;
      a_edge <= load_edges ? a_nxt : '0;
      b_edge <= load_edges ? b_nxt : '0;
    end
  end

  // NOTE: operand buffers carry no reset; a job always overwrites them fully before they are read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (idx < IW'(NN)) a_mem[AW'(idx)]          <= s_data;
      else               b_mem[AW'(idx - IW'(NN))] <= s_data;
    end
  end

`ifdef SKEW_FEEDER_JOB_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                job_cnt <= '0;
    else if (state == DONE) job_cnt <= job_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=4, DW=32): load, skewed feed, stalls, ignored words, mid-job reset.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BW = N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [BW-1:0] a_edge;
  logic [BW-1:0] b_edge;
  logic          edge_valid;
  logic          acc_clr;
  logic          busy;
  logic          done;
`ifdef SKEW_FEEDER_JOB_CNT_EN
  logic [15:0]   job_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int jobs     = 0;

  systolic_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .a_edge     (a_edge),
    .b_edge     (b_edge),
    .edge_valid (edge_valid),
    .acc_clr    (acc_clr),
    .busy       (busy),
    .done       (done)
`ifdef SKEW_FEEDER_JOB_CNT_EN
    ,
    .job_cnt    (job_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  // A[i][k] = 10i+k+1 for words 0..15, B[k][j] = 100+10k+j for words 16..31.
  function automatic logic [DW-1:0] word(input int w);
    if (w < N * N) return DW'(10 * (w / N) + (w % N) + 1);
    return DW'(100 + 10 * ((w - N * N) / N) + ((w - N * N) % N));
  endfunction

  function automatic logic [BW-1:0] exp_edge(input bit is_b, input int s);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = s - i;
      if (k >= 0 && k < N)
        v[i*DW +: DW] = is_b ? DW'(100 + 10 * k + i) : DW'(10 * i + k + 1);
    end
    return v;
  endfunction

  // Streams 32 words; gap=1 drops s_valid every other cycle. Ends at the negedge after the last accept.
  task automatic stream(input bit gap, input int exp_cycles);
    int w;
    int cycles;
    w      = 0;
    cycles = 0;
    while (w < 2 * N * N && cycles < 200) begin
      if (gap && cycles % 2 == 1) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = word(w);
      end
      if (s_valid && s_ready) w++;
      @(negedge clk);
      cycles++;
    end
    s_valid = 1'b0;
    check("load_cycles", BW'(cycles), BW'(exp_cycles));
  endtask

  // Called at the negedge of the CLR cycle; runs through the first LOAD cycle after DONE.
  task automatic run_job(input bit poke, input bit spot);
    check("clr_acc_clr", BW'(acc_clr), BW'(1));
    check("clr_busy", BW'(busy), BW'(1));
    check("clr_quiet", {a_edge, b_edge, BW'(edge_valid), BW'(s_ready)}, '0);
    if (poke) begin
      s_valid = 1'b1;
      s_data  = 32'hDEAD;
    end
    for (int s = 0; s < 3 * N - 2; s++) begin
      @(negedge clk);
      check($sformatf("feed_valid_t%0d", s), {BW'(edge_valid), BW'(acc_clr), BW'(s_ready)},
            {BW'(1), BW'(0), BW'(0)});
      check($sformatf("a_edge_t%0d", s), a_edge, exp_edge(1'b0, s));
      check($sformatf("b_edge_t%0d", s), b_edge, exp_edge(1'b1, s));
      if (spot) begin
        if (s == 0) begin
          check("a_t0", a_edge, pack(1, 0, 0, 0));
          check("b_t0", b_edge, pack(100, 0, 0, 0));
        end
        if (s == 3) begin
          check("a_t3", a_edge, pack(4, 13, 22, 31));
          check("b_t3", b_edge, pack(130, 121, 112, 103));
        end
        if (s == 6) begin
          check("a_t6", a_edge, pack(0, 0, 0, 34));
          check("b_t6", b_edge, pack(0, 0, 0, 133));
        end
        if (s == 9) check("ab_t9", {a_edge, b_edge}, '0);
      end
    end
    for (int d = 0; d < N; d++) begin
      @(negedge clk);
      check($sformatf("drain_%0d", d), {a_edge, b_edge, BW'(edge_valid), BW'(done), BW'(busy)},
            {BW'(0), BW'(0), BW'(0), BW'(0), BW'(1)});
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("done_pulse", {BW'(done), BW'(busy), BW'(s_ready)}, {BW'(1), BW'(1), BW'(0)});
    check("done_edges", {a_edge, b_edge, BW'(edge_valid)}, '0);
    @(negedge clk);
    jobs++;
    check("post_done", {BW'(done), BW'(busy), BW'(s_ready)}, {BW'(0), BW'(0), BW'(1)});
`ifdef SKEW_FEEDER_JOB_CNT_EN
    check("job_cnt", BW'(job_cnt), BW'(jobs));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    repeat (3) @(negedge clk);
    check("rst_outputs", {a_edge, b_edge}, '0);
    check("rst_flags", {BW'(edge_valid), BW'(acc_clr), BW'(busy), BW'(done), BW'(s_ready)}, '0);
    s_valid = 1'b0;
    rst     = 1'b0;
    #1;
    check("rel_s_ready", BW'(s_ready), BW'(1));
`ifdef SKEW_FEEDER_JOB_CNT_EN
    check("rst_job_cnt", BW'(job_cnt), '0);
`endif

    // Back-to-back load, spot-checked slots.
    stream(1'b0, 2 * N * N);
    run_job(1'b0, 1'b1);

    // Stalled load with junk words offered while busy.
    stream(1'b1, 4 * N * N - 1);
    run_job(1'b1, 1'b1);

    // Reset in FEED at slot 5, then a fresh job.
    stream(1'b0, 2 * N * N);
    check("abort_clr", BW'(acc_clr), BW'(1));
    repeat (6) @(negedge clk);
    check("abort_pre_t5", a_edge, exp_edge(1'b0, 5));
    rst = 1'b1;
    @(negedge clk);
    check("abort_edges", {a_edge, b_edge}, '0);
    check("abort_flags", {BW'(edge_valid), BW'(busy), BW'(done), BW'(s_ready)}, '0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("abort_idle_%0d", c), {BW'(done), BW'(busy), BW'(s_ready)},
            {BW'(0), BW'(0), BW'(1)});
      @(negedge clk);
    end
    stream(1'b0, 2 * N * N);
    run_job(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
